reg_writeback_queue: RTL and testbench

//   Write-side initiator for the CPU register file: buffers writeback requests from the
//   ALU/memory stages in a small FIFO and drives the register-file write port
//   (RegWre/Rd/WriteData) at most once per cycle. Also forwards pending (not yet

---
 rtl/reg_writeback_queue_pkg.sv | 9 +
 rtl/reg_writeback_queue_fifo.sv | 88 ++++++++
 rtl/reg_writeback_queue.sv | 124 ++++++++++++
 tb/tb_reg_writeback_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_queue_pkg.sv
// Shared constants for the register-file writeback queue.
package reg_writeback_queue_pkg;

  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_AW    = 5;
  localparam int unsigned DEF_DW    = 32;
  localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/reg_writeback_queue_fifo.sv
// Circular FIFO of pending register writes; exposes all entries in age order
// (index 0 = oldest) together with a valid mask for the forwarding search.
module reg_writeback_queue_fifo
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [AW-1:0] push_rd_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [AW-1:0] head_rd_o,
  output logic [DW-1:0] head_data_o,
  output logic [CW-1:0] count_o,
  output logic [AW-1:0] ent_rd_o   [DEPTH],
  output logic [DW-1:0] ent_data_o [DEPTH],
  output logic          ent_vld_o  [DEPTH]
);

  logic [AW-1:0] rd_mem_q   [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !flush_i && (count_q < CW'(DEPTH));
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem_q[wr_ptr_q]   <= push_rd_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_rd_o   = rd_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];
  assign count_o     = count_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    logic [PW-1:0] slot;
    assign slot          = rd_ptr_q + PW'(k);
    assign ent_rd_o[k]   = rd_mem_q[slot];
    assign ent_data_o[k] = data_mem_q[slot];
    assign ent_vld_o[k]  = (CW'(k) < count_q);
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Register-file write initiator: queues writebacks, drains one per cycle onto
// the registered write port, and forwards the newest pending value for Rs/Rt.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rd,
  input  logic [DW-1:0] in_data,
  output logic          RegWre,
  output logic [AW-1:0] Rd,
  output logic [DW-1:0] WriteData,
  input  logic [AW-1:0] Rs,
  input  logic [AW-1:0] Rt,
  output logic          fwd_hit1,
  output logic [DW-1:0] fwd_data1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data2,
  output logic [CW-1:0] count
);

  logic          push, pop;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_data;
  logic [AW-1:0] ent_rd   [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic          ent_vld  [DEPTH];
  logic          regwre_q, regwre_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // Full is judged on the pre-edge count only; a same-edge pop does not help.
  assign in_ready = (count < CW'(DEPTH)) && RST_n;
  assign push     = in_valid && in_ready && (in_rd != AW'(REG_ZERO));
  assign pop      = (count != '0);

  reg_writeback_queue_fifo #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RST_n),
    .flush_i    (flush),
    .push_i     (push),
    .push_rd_i  (in_rd),
    .push_data_i(in_data),
    .pop_i      (pop),
    .head_rd_o  (head_rd),
    .head_data_o(head_data),
    .count_o    (count),
    .ent_rd_o   (ent_rd),
    .ent_data_o (ent_data),
    .ent_vld_o  (ent_vld)
  );

  always_comb begin
    regwre_d = 1'b0;
    rd_d     = rd_q;
    wdata_d  = wdata_q;
    if (!flush && pop) begin
      regwre_d = 1'b1;
      rd_d     = head_rd;
      wdata_d  = head_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      regwre_q <= 1'b0;
      rd_q     <= '0;
      wdata_q  <= '0;
    end else begin
      regwre_q <= regwre_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
    end
  end

  assign RegWre    = regwre_q;
  assign Rd        = rd_q;
  assign WriteData = wdata_q;

  // Scan oldest (output port) to youngest so later matches override earlier ones.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    if (regwre_q && rd_q == Rs) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = wdata_q;
    end
    if (regwre_q && rd_q == Rt) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = wdata_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld[k] && ent_rd[k] == Rs) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = ent_data[k];
      end
      if (ent_vld[k] && ent_rd[k] == Rt) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = ent_data[k];
      end
    end
    if (Rs == AW'(REG_ZERO)) begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
    end
    if (Rt == AW'(REG_ZERO)) begin
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench: a queue-based reference model predicts each register write
// and forwarding result; a negedge monitor compares DUT outputs against it.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_data = '0;
  logic        RegWre;
  logic [4:0]  Rd;
  logic [31:0] WriteData;
  logic [4:0]  Rs = '0;
  logic [4:0]  Rt = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  count;

  int n_chk = 0;
  int n_fail = 0;

  ent_t        pend[$];
  ent_t        exp_q[$];
  ent_t        port_m;
  bit          port_vld_m = 0;
  logic [31:0] regfile [32];

  reg_writeback_queue dut (
    .CLK(CLK), .RST_n(RST_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data), .RegWre(RegWre),
    .Rd(Rd), .WriteData(WriteData), .Rs(Rs), .Rt(Rt), .fwd_hit1(fwd_hit1),
    .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void fwd_exp(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 0) begin
      for (int i = pend.size() - 1; i >= 0; i--)
        if (!hit && pend[i].rd == a) begin
          hit = 1'b1;
          d   = pend[i].data;
        end
      if (!hit && port_vld_m && port_m.rd == a) begin
        hit = 1'b1;
        d   = port_m.data;
      end
    end
  endfunction

  // Reference model: one pop from the pending list per edge, then the push.
  always @(posedge CLK) begin
    if (RST_n) begin
      int sz;
      sz = pend.size();
      port_vld_m = 0;
      if (flush) begin
        pend.delete();
      end else begin
        if (sz > 0) begin
          port_m = pend.pop_front();
          port_vld_m = 1;
          exp_q.push_back(port_m);
        end
        if (in_valid && sz < DEPTH && in_rd != 0)
          pend.push_back('{rd: in_rd, data: in_data});
      end
    end
  end

  // Monitor: compare write port, occupancy and forwarding half a cycle later.
  always @(negedge CLK) begin
    if (RST_n) begin
      logic        h;
      logic [31:0] d;
      chk("regwre", RegWre, port_vld_m);
      if (RegWre) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("rd", Rd, e.rd);
          chk("wdata", WriteData, e.data);
        end
        regfile[Rd] = WriteData;
      end
      chk("count", count, pend.size());
      chk("in_ready", in_ready, pend.size() < DEPTH);
      fwd_exp(Rs, h, d);
      chk("fwd_hit1", fwd_hit1, h);
      chk("fwd_data1", fwd_data1, d);
      fwd_exp(Rt, h, d);
      chk("fwd_hit2", fwd_hit2, h);
      chk("fwd_data2", fwd_data2, d);
    end
  end

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] data,
                       input logic fl, input logic [4:0] rs, input logic [4:0] rt);
    @(posedge CLK);
    #1;
    in_valid = v;
    in_rd    = rd;
    in_data  = data;
    flush    = fl;
    Rs       = rs;
    Rt       = rt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_regwre"}, RegWre, 0);
    chk({tag, "_rd"}, Rd, 0);
    chk({tag, "_wdata"}, WriteData, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = '0;
    #2;
    check_reset_state("reset");
    repeat (2) @(posedge CLK);
    #1 RST_n = 1'b1;

    // Single write, then register-file contents.
    drive(1, 5'd3, 32'h1234, 0, 5'd3, 0);
    idle(3);
    chk("regfile_r3", regfile[3], 32'h1234);

    // Back-to-back pushes rd 1..5.
    for (int i = 1; i <= 5; i++) drive(1, 5'(i), $urandom, 0, 5'(i), 5'(i - 1));
    idle(3);

    // Two writes to r7: newest value must be forwarded.
    drive(1, 5'd7, 32'hA, 0, 5'd7, 0);
    drive(1, 5'd7, 32'hB, 0, 5'd7, 0);
    drive(0, 0, 0, 0, 5'd7, 0);
    idle(2);

    // Writes to r0 are swallowed.
    drive(1, 5'd0, 32'hFFFF, 0, 0, 0);
    drive(1, 5'd0, 32'hFFFF, 0, 0, 0);
    idle(2);

    // Flush with a push in the same cycle.
    drive(1, 5'd4, 32'h44, 0, 5'd4, 0);
    drive(1, 5'd5, 32'h55, 0, 5'd5, 0);
    drive(1, 5'd9, 32'h99, 1, 5'd9, 5'd5);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 19) == 0), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));

    // Reset mid-operation: outputs clear without waiting for a clock edge.
    drive(1, 5'd6, 32'h66, 0, 0, 0);
    drive(1, 5'd2, 32'h22, 0, 0, 0);
    @(posedge CLK);
    #3 RST_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_state("midreset");
    pend.delete();
    exp_q.delete();
    port_vld_m = 0;
    @(posedge CLK);
    #1 RST_n = 1'b1;
    drive(1, 5'd1, 32'hCAFE, 0, 5'd1, 0);
    idle(4);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
